// File: rtl/arb_rr_n.sv
// Round-robin arbiter: NUM_PORTS requesters share one registered master port,
// with a watchdog that aborts transactions the slave never completes.
module arb_rr_n #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int TIMEOUT   = 256,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr_a,
  input  logic [NUM_PORTS*DATA_W-1:0]   dout_a,
  output logic [NUM_PORTS*DATA_W-1:0]   din_a,
  input  logic [NUM_PORTS-1:0]          req_a,
  input  logic [NUM_PORTS-1:0]          wr_a,
  output logic [NUM_PORTS-1:0]          rdy_a,
  output logic [NUM_PORTS-1:0]          err_a,
  output logic [ADDR_W-1:0]             addr_m,
  output logic [DATA_W-1:0]             dout_m,
  input  logic [DATA_W-1:0]             din_m,
  output logic                          req_m,
  output logic                          wr_m,
  input  logic                          rdy_m,
  output logic [IDX_W-1:0]              gnt_id,
  output logic                          busy
);

  localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   req_m_q, req_m_d;
  logic                   wr_m_q, wr_m_d;
  logic [ADDR_W-1:0]      addr_m_q, addr_m_d;
  logic [DATA_W-1:0]      dout_m_q, dout_m_d;
  logic [NUM_PORTS-1:0]   err_q, err_d;
  logic [WDOG_W-1:0]      wdog_q, wdog_d;

  logic [IDX_W:0]         cand_sum [NUM_PORTS];
  logic [IDX_W-1:0]       cand_idx [NUM_PORTS];
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic                   timeout_hit;

  // cand_idx[gi] is the port at rotating offset gi+1 from the last winner
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, last_q} + (IDX_W+1)'(gi + 1);
    assign cand_idx[gi] = (cand_sum[gi] >= (IDX_W+1)'(NUM_PORTS))
                        ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_PORTS))
                        : IDX_W'(cand_sum[gi]);
  end

  // Scan from lowest priority upward so the nearest requester is written last
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_a[cand_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (wdog_q == WDOG_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    req_m_d  = req_m_q;
    wr_m_d   = wr_m_q;
    addr_m_d = addr_m_q;
    dout_m_d = dout_m_q;
    err_d    = '0;
    wdog_d   = wdog_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = BUSY;
          cur_d    = win_idx;
          req_m_d  = 1'b1;
          wr_m_d   = wr_a[win_idx];
          addr_m_d = addr_a[win_idx*ADDR_W +: ADDR_W];
          dout_m_d = dout_a[win_idx*DATA_W +: DATA_W];
          wdog_d   = '0;
        end
      end
      BUSY: begin
        if (rdy_m) begin
          state_d = IDLE;
          req_m_d = 1'b0;
          last_d  = cur_q;
          wdog_d  = '0;
        end else if (timeout_hit) begin
          state_d       = IDLE;
          req_m_d       = 1'b0;
          last_d        = cur_q;
          err_d[cur_q]  = 1'b1;
          wdog_d        = '0;
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      last_q   <= IDX_W'(NUM_PORTS - 1);
      req_m_q  <= 1'b0;
      wr_m_q   <= 1'b0;
      addr_m_q <= '0;
      dout_m_q <= '0;
      err_q    <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      req_m_q  <= req_m_d;
      wr_m_q   <= wr_m_d;
      addr_m_q <= addr_m_d;
      dout_m_q <= dout_m_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  assign busy   = (state_q == BUSY);
  assign gnt_id = cur_q;
  assign req_m  = req_m_q;
  assign wr_m   = wr_m_q;
  assign addr_m = addr_m_q;
  assign dout_m = dout_m_q;
  assign err_a  = err_q;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign rdy_a[gi]                    = rdy_m & busy & (cur_q == IDX_W'(gi));
    assign din_a[gi*DATA_W +: DATA_W]   = din_m;
  end

endmodule

// File: tb/tb_arb_rr_n.sv
// Directed bench for arb_rr_n: per-cycle vector table plus hand sequences for
// field capture, watchdog abort and asynchronous reset.
module tb_arb_rr_n;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*AW-1:0]   addr_a;
  logic [N*DW-1:0]   dout_a;
  logic [N*DW-1:0]   din_a;
  logic [N-1:0]      req_a, wr_a, rdy_a, err_a;
  logic [AW-1:0]     addr_m;
  logic [DW-1:0]     dout_m, din_m;
  logic              req_m, wr_m, rdy_m, busy;
  logic [1:0]        gnt_id;

  arb_rr_n #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .addr_a(addr_a), .dout_a(dout_a), .din_a(din_a),
    .req_a(req_a), .wr_a(wr_a), .rdy_a(rdy_a), .err_a(err_a), .addr_m(addr_m),
    .dout_m(dout_m), .din_m(din_m), .req_m(req_m), .wr_m(wr_m), .rdy_m(rdy_m),
    .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       exp_req_m;
    logic       exp_busy;
    logic [1:0] exp_gnt;
    logic [3:0] exp_rdy_a;
    logic [3:0] exp_err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] req, input logic rdy, input logic rq,
                              input logic bz, input logic [1:0] g, input logic [3:0] ra,
                              input logic [3:0] ea);
    vec_t v;
    v.req = req; v.rdy = rdy; v.exp_req_m = rq; v.exp_busy = bz;
    v.exp_gnt = g; v.exp_rdy_a = ra; v.exp_err = ea;
    vecs.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int busy_cnt;

    // Round-robin over all four ports, then an IDLE with rdy_m ignored
    add(4'hF,0, 0,0,0,4'h0,4'h0);
    add(4'hF,1, 1,1,0,4'h1,4'h0);
    add(4'hF,0, 0,0,0,4'h0,4'h0);
    add(4'hF,1, 1,1,1,4'h2,4'h0);
    add(4'hF,0, 0,0,1,4'h0,4'h0);
    add(4'hF,1, 1,1,2,4'h4,4'h0);
    add(4'hF,0, 0,0,2,4'h0,4'h0);
    add(4'hF,1, 1,1,3,4'h8,4'h0);
    add(4'hF,0, 0,0,3,4'h0,4'h0);
    add(4'hF,1, 1,1,0,4'h1,4'h0);
    add(4'h0,1, 0,0,0,4'h0,4'h0);
    add(4'h0,0, 0,0,0,4'h0,4'h0);
    // Port 3 alone re-granted after one IDLE, then port 0 beats port 3
    add(4'h8,0, 0,0,0,4'h0,4'h0);
    add(4'h8,1, 1,1,3,4'h8,4'h0);
    add(4'h8,0, 0,0,3,4'h0,4'h0);
    add(4'h9,0, 1,1,3,4'h0,4'h0);
    add(4'h9,1, 1,1,3,4'h8,4'h0);
    add(4'h9,0, 0,0,3,4'h0,4'h0);
    add(4'h0,1, 1,1,0,4'h1,4'h0);
    add(4'h0,0, 0,0,0,4'h0,4'h0);
    // Port 1: rdy_m on the 8th BUSY cycle beats the watchdog
    add(4'h2,0, 0,0,0,4'h0,4'h0);
    for (int i = 0; i < 7; i++) add(4'h0,0, 1,1,1,4'h0,4'h0);
    add(4'h0,1, 1,1,1,4'h2,4'h0);
    add(4'h0,0, 0,0,1,4'h0,4'h0);
    add(4'h0,0, 0,0,1,4'h0,4'h0);

    reset = 1'b1; req_a = '0; wr_a = '0; rdy_m = 1'b0; din_m = 64'h0;
    for (int i = 0; i < N; i++) begin
      addr_a[i*AW +: AW] = 64'h1000 + 64'(i);
      dout_a[i*DW +: DW] = 64'hA000 + 64'(i);
    end
    @(negedge clk); @(negedge clk); #1;
    chk("rst_req_m", 64'(req_m), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_gnt", 64'(gnt_id), 64'h0);
    chk("rst_err", 64'(err_a), 64'h0);
    chk("rst_addr_m", addr_m, 64'h0);
    chk("rst_dout_m", dout_m, 64'h0);
    chk("rst_wr_m", 64'(wr_m), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req_a = vecs[i].req;
      rdy_m = vecs[i].rdy;
      #1;
      $display("vec %0d req_a=%b rdy_m=%b -> req_m=%b busy=%b gnt=%0d rdy_a=%b err_a=%b",
               i, req_a, rdy_m, req_m, busy, gnt_id, rdy_a, err_a);
      chk($sformatf("v%0d_req_m", i), 64'(req_m), 64'(vecs[i].exp_req_m));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      chk($sformatf("v%0d_gnt", i), 64'(gnt_id), 64'(vecs[i].exp_gnt));
      chk($sformatf("v%0d_rdy_a", i), 64'(rdy_a), 64'(vecs[i].exp_rdy_a));
      chk($sformatf("v%0d_err_a", i), 64'(err_a), 64'(vecs[i].exp_err));
    end

    // Watchdog abort on port 1: 8 BUSY cycles then a one-cycle err strobe
    @(negedge clk);
    req_a = 4'b0010; rdy_m = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_a = '0;
      #1;
      if (busy) begin
        busy_cnt++;
        chk("to_rdy_a", 64'(rdy_a), 64'h0);
        chk("to_err_early", 64'(err_a), 64'h0);
      end else if (busy_cnt > 0) begin
        break;
      end
    end
    $display("timeout: busy cycles=%0d req_m=%b err_a=%b", busy_cnt, req_m, err_a);
    chk("to_busy_cycles", 64'(busy_cnt), 64'd8);
    chk("to_req_m", 64'(req_m), 64'h0);
    chk("to_err_a", 64'(err_a), 64'h2);
    chk("to_gnt", 64'(gnt_id), 64'h1);
    @(negedge clk); #1;
    chk("to_err_clear", 64'(err_a), 64'h0);

    // Port 2 capture; its slice changes mid-BUSY but master fields hold
    @(negedge clk);
    addr_a[2*AW +: AW] = 64'h40;
    dout_a[2*DW +: DW] = 64'hDEAD_BEEF_0000_0002;
    wr_a = 4'b0100; req_a = 4'b0100;
    @(negedge clk); #1;
    chk("cap_gnt", 64'(gnt_id), 64'h2);
    chk("cap_addr", addr_m, 64'h40);
    chk("cap_dout", dout_m, 64'hDEAD_BEEF_0000_0002);
    chk("cap_wr", 64'(wr_m), 64'h1);
    addr_a[2*AW +: AW] = 64'h80;
    dout_a[2*DW +: DW] = 64'h0;
    wr_a = '0; req_a = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("hold_addr", addr_m, 64'h40);
      chk("hold_wr", 64'(wr_m), 64'h1);
      chk("hold_req_m", 64'(req_m), 64'h1);
    end
    @(negedge clk);
    rdy_m = 1'b1; din_m = 64'h1234_5678_9ABC_DEF0;
    #1;
    $display("capture: addr_m=0x%0h rdy_a=%b", addr_m, rdy_a);
    chk("cap_rdy_a", 64'(rdy_a), 64'h4);
    chk("cap_addr_end", addr_m, 64'h40);
    chk("din_a0", din_a[0 +: DW], 64'h1234_5678_9ABC_DEF0);
    chk("din_a3", din_a[3*DW +: DW], 64'h1234_5678_9ABC_DEF0);
    @(negedge clk);
    rdy_m = 1'b0;
    #1;
    chk("cap_done_busy", 64'(busy), 64'h0);
    chk("cap_done_req_m", 64'(req_m), 64'h0);

    // Asynchronous reset while port 3 is BUSY
    @(negedge clk);
    req_a = 4'b1000;
    @(negedge clk); #1;
    chk("ar_pre_busy", 64'(busy), 64'h1);
    chk("ar_pre_gnt", 64'(gnt_id), 64'h3);
    rdy_m = 1'b1;
    #1 reset = 1'b1;
    #1;
    $display("async reset: req_m=%b busy=%b gnt=%0d rdy_a=%b", req_m, busy, gnt_id, rdy_a);
    chk("ar_req_m", 64'(req_m), 64'h0);
    chk("ar_busy", 64'(busy), 64'h0);
    chk("ar_gnt", 64'(gnt_id), 64'h0);
    chk("ar_rdy_a", 64'(rdy_a), 64'h0);
    chk("ar_err_a", 64'(err_a), 64'h0);
    @(negedge clk);
    reset = 1'b0; rdy_m = 1'b0; req_a = 4'b0110;
    @(negedge clk); #1;
    $display("after reset: gnt=%0d busy=%b", gnt_id, busy);
    chk("ar_first_gnt", 64'(gnt_id), 64'h1);
    chk("ar_first_busy", 64'(busy), 64'h1);
    chk("ar_first_req_m", 64'(req_m), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
